// File: rtl/memgame_pkg.sv
// Shared constants for the Memory Game: board size, default geometry and
// the reveal/compare/hide state encoding.
package memgame_pkg;

  localparam int NCARDS    = 16;
  localparam int GRID_COLS = 4;
  localparam int GRID_ROWS = 4;

  localparam int DEF_GRID_X0     = 50;
  localparam int DEF_GRID_Y0     = 30;
  localparam int DEF_CARD_W      = 150;
  localparam int DEF_CARD_H      = 120;
  localparam int DEF_GAP         = 20;
  localparam int DEF_HOLD_CYCLES = 40_000_000;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_ONE  = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

endpackage

// File: rtl/card_hit_decoder.sv
// Maps a click position to a card index on the 4x4 board using range
// compares only; gaps and off-board positions give no hit.
module card_hit_decoder
  import memgame_pkg::*;
#(
  parameter int GRID_X0 = DEF_GRID_X0,
  parameter int GRID_Y0 = DEF_GRID_Y0,
  parameter int CARD_W  = DEF_CARD_W,
  parameter int CARD_H  = DEF_CARD_H,
  parameter int GAP     = DEF_GAP
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        flush,
  input  logic        click,
  input  logic [10:0] click_x,
  input  logic [10:0] click_y,
  output logic        hit_valid,
  output logic [3:0]  hit_idx
);

  logic [31:0] x_val;
  logic [31:0] y_val;
  logic [31:0] col_lo;
  logic [31:0] row_lo;
  logic        col_hit;
  logic        row_hit;
  logic [1:0]  col_idx;
  logic [1:0]  row_idx;

  assign x_val = {21'd0, click_x};
  assign y_val = {21'd0, click_y};

  // Cells are disjoint, so at most one column and one row can match.
  always_comb begin
    col_lo  = '0;
    row_lo  = '0;
    col_hit = 1'b0;
    row_hit = 1'b0;
    col_idx = '0;
    row_idx = '0;
    for (int c = 0; c < GRID_COLS; c++) begin
      col_lo = 32'(GRID_X0 + c * (CARD_W + GAP));
      if (x_val >= col_lo && x_val < col_lo + 32'(CARD_W)) begin
        col_hit = 1'b1;
        col_idx = 2'(c);
      end
    end
    for (int r = 0; r < GRID_ROWS; r++) begin
      row_lo = 32'(GRID_Y0 + r * (CARD_H + GAP));
      if (y_val >= row_lo && y_val < row_lo + 32'(CARD_H)) begin
        row_hit = 1'b1;
        row_idx = 2'(r);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst || flush) begin
      hit_valid <= 1'b0;
      hit_idx   <= '0;
    end else begin
      hit_valid <= click && col_hit && row_hit;
      if (click) begin
        hit_idx <= {row_idx, col_idx};
      end
    end
  end

endmodule

// File: rtl/card_flip_ctrl.sv
// Memory Game controller: decodes clicks to cards and runs the
// reveal/compare/hide sequence that drives the card overlay drawers.
module card_flip_ctrl
  import memgame_pkg::*;
#(
  parameter int GRID_X0     = DEF_GRID_X0,
  parameter int GRID_Y0     = DEF_GRID_Y0,
  parameter int CARD_W      = DEF_CARD_W,
  parameter int CARD_H      = DEF_CARD_H,
  parameter int GAP         = DEF_GAP,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        click,
  input  logic [10:0] click_x,
  input  logic [10:0] click_y,
  input  logic [63:0] card_values,
  output logic [15:0] visible_mask,
  output logic [15:0] matched_mask,
  output logic [7:0]  moves,
  output logic        busy,
  output logic        game_done
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic              hit_valid;
  logic [3:0]        hit_idx;
  logic              accept;
  logic [1:0]        state, state_n;
  logic [NCARDS-1:0] reveal, reveal_n, matched_n;
  logic [7:0]        moves_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [3:0]        first_idx, first_n, second_idx, second_n;

  card_hit_decoder #(
    .GRID_X0 (GRID_X0),
    .GRID_Y0 (GRID_Y0),
    .CARD_W  (CARD_W),
    .CARD_H  (CARD_H),
    .GAP     (GAP)
  ) u_hit (
    .pclk      (pclk),
    .rst       (rst),
    .flush     (new_game),
    .click     (click),
    .click_x   (click_x),
    .click_y   (click_y),
    .hit_valid (hit_valid),
    .hit_idx   (hit_idx)
  );

  assign accept = hit_valid && !reveal[hit_idx] && !matched_mask[hit_idx];
  assign busy   = (state == ST_SHOW);

  // new_game is applied last so it overrides whatever the FSM decided.
  always_comb begin
    state_n   = state;
    reveal_n  = reveal;
    matched_n = matched_mask;
    moves_n   = moves;
    hold_n    = hold_cnt;
    first_n   = first_idx;
    second_n  = second_idx;
    case (state)
      ST_NONE: begin
        if (accept) begin
          reveal_n[hit_idx] = 1'b1;
          first_n           = hit_idx;
          state_n           = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept) begin
          reveal_n[hit_idx] = 1'b1;
          second_n          = hit_idx;
          hold_n            = HOLD_LOAD;
          moves_n           = (moves == 8'hFF) ? moves : moves + 8'd1;
          state_n           = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (hold_cnt == '0) begin
          if (card_values[{first_idx, 2'b00} +: 4] == card_values[{second_idx, 2'b00} +: 4]) begin
            matched_n[first_idx]  = 1'b1;
            matched_n[second_idx] = 1'b1;
          end
          reveal_n[first_idx]  = 1'b0;
          reveal_n[second_idx] = 1'b0;
          state_n              = ST_NONE;
        end else begin
          hold_n = hold_cnt - HOLD_W'(1);
        end
      end
      default: state_n = ST_NONE;
    endcase
    if (new_game) begin
      state_n   = ST_NONE;
      reveal_n  = '0;
      matched_n = '0;
      moves_n   = '0;
      hold_n    = '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= ST_NONE;
      reveal       <= '0;
      matched_mask <= '0;
      visible_mask <= '0;
      moves        <= '0;
      hold_cnt     <= '0;
      first_idx    <= '0;
      second_idx   <= '0;
      game_done    <= 1'b0;
    end else begin
      state        <= state_n;
      reveal       <= reveal_n;
      matched_mask <= matched_n;
      visible_mask <= reveal_n | matched_n;
      moves        <= moves_n;
      hold_cnt     <= hold_n;
      first_idx    <= first_n;
      second_idx   <= second_n;
      game_done    <= !new_game && (matched_mask == 16'hFFFF);
    end
  end

endmodule

// File: tb/tb_card_flip_ctrl.sv
// Directed bench for card_flip_ctrl with a short hold time: hit-decode
// vector table plus hand-written match/mismatch/ignore/reset sequences.
module tb_card_flip_ctrl;

  localparam int HOLD = 4;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] vis;
  } hit_vec_t;

  logic        pclk = 1'b0;
  logic        rst;
  logic        new_game;
  logic        click;
  logic [10:0] click_x;
  logic [10:0] click_y;
  logic [63:0] card_values;
  logic [15:0] visible_mask;
  logic [15:0] matched_mask;
  logic [7:0]  moves;
  logic        busy;
  logic        game_done;

  int n_checks = 0;
  int n_errors = 0;

  hit_vec_t vecs[13];

  card_flip_ctrl #(
    .HOLD_CYCLES (HOLD)
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .new_game     (new_game),
    .click        (click),
    .click_x      (click_x),
    .click_y      (click_y),
    .card_values  (card_values),
    .visible_mask (visible_mask),
    .matched_mask (matched_mask),
    .moves        (moves),
    .busy         (busy),
    .game_done    (game_done)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] card_x(input int i);
    return 11'(50 + (i % 4) * 170 + 10);
  endfunction

  function automatic logic [10:0] card_y(input int i);
    return 11'(30 + (i / 4) * 140 + 10);
  endfunction

  task automatic apply_stimulus(input logic [10:0] x, input logic [10:0] y);
    click   = 1'b1;
    click_x = x;
    click_y = y;
    tick();
    click = 1'b0;
    tick();
  endtask

  task automatic click_card(input int i);
    apply_stimulus(card_x(i), card_y(i));
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  task automatic wait_show_end(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 50) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    vecs[0]  = '{x: 11'd50,   y: 11'd30,  vis: 16'h0001};
    vecs[1]  = '{x: 11'd199,  y: 11'd149, vis: 16'h0001};
    vecs[2]  = '{x: 11'd200,  y: 11'd30,  vis: 16'h0000};
    vecs[3]  = '{x: 11'd220,  y: 11'd170, vis: 16'h0020};
    vecs[4]  = '{x: 11'd49,   y: 11'd30,  vis: 16'h0000};
    vecs[5]  = '{x: 11'd50,   y: 11'd29,  vis: 16'h0000};
    vecs[6]  = '{x: 11'd709,  y: 11'd30,  vis: 16'h0008};
    vecs[7]  = '{x: 11'd710,  y: 11'd30,  vis: 16'h0000};
    vecs[8]  = '{x: 11'd50,   y: 11'd569, vis: 16'h1000};
    vecs[9]  = '{x: 11'd50,   y: 11'd570, vis: 16'h0000};
    vecs[10] = '{x: 11'd2047, y: 11'd2047, vis: 16'h0000};
    vecs[11] = '{x: 11'd389,  y: 11'd310, vis: 16'h0000};
    vecs[12] = '{x: 11'd390,  y: 11'd310, vis: 16'h0400};

    // Pairs (2k, 2k+1) share face value k+3; cards 0 and 2 differ.
    for (int i = 0; i < 16; i++) card_values[4*i +: 4] = 4'((i / 2) + 3);

    rst = 1'b1; new_game = 1'b0; click = 1'b0; click_x = '0; click_y = '0;
    tick();
    tick();
    rst = 1'b0;
    check_output("reset visible_mask", 32'(visible_mask), 32'h0);
    check_output("reset matched_mask", 32'(matched_mask), 32'h0);
    check_output("reset moves", 32'(moves), 32'h0);
    check_output("reset busy", 32'(busy), 32'h0);
    check_output("reset game_done", 32'(game_done), 32'h0);

    click = 1'b1; click_x = 11'd50; click_y = 11'd30;
    tick();
    click = 1'b0;
    check_output("latency after edge k", 32'(visible_mask), 32'h0);
    tick();
    check_output("latency after edge k+1", 32'(visible_mask), 32'h0001);

    for (int v = 0; v < 13; v++) begin
      pulse_new_game();
      apply_stimulus(vecs[v].x, vecs[v].y);
      check_output($sformatf("hit vec %0d visible", v), 32'(visible_mask), 32'(vecs[v].vis));
      check_output($sformatf("hit vec %0d busy", v), 32'(busy), 32'h0);
    end

    pulse_new_game();
    click_card(0);
    check_output("match first reveal", 32'(visible_mask), 32'h0001);
    click_card(1);
    check_output("match busy rises", 32'(busy), 32'h1);
    check_output("match both revealed", 32'(visible_mask), 32'h0003);
    check_output("match moves", 32'(moves), 32'h1);
    wait_show_end(n);
    check_output("match show length", 32'(n), 32'(HOLD));
    check_output("match matched_mask", 32'(matched_mask), 32'h0003);
    check_output("match visible_mask", 32'(visible_mask), 32'h0003);

    click_card(0);
    check_output("ignore matched card", 32'(visible_mask), 32'h0003);
    click_card(4);
    click_card(4);
    check_output("ignore same card in ONE", 32'(visible_mask), 32'h0013);
    check_output("ignore same card busy", 32'(busy), 32'h0);
    check_output("ignore moves unchanged", 32'(moves), 32'h1);
    click_card(5);
    check_output("second pair moves", 32'(moves), 32'h2);
    click_card(6);
    check_output("ignore click in SHOW", 32'(visible_mask), 32'h0033);
    wait_show_end(n);
    check_output("second pair matched", 32'(matched_mask), 32'h0033);
    check_output("moves after ignored", 32'(moves), 32'h2);

    pulse_new_game();
    click = 1'b1; click_x = card_x(8); click_y = card_y(8);
    tick();
    click_x = card_x(9); click_y = card_y(9);
    tick();
    click = 1'b0;
    tick();
    check_output("consecutive clicks visible", 32'(visible_mask), 32'h0300);
    check_output("consecutive clicks busy", 32'(busy), 32'h1);
    wait_show_end(n);

    pulse_new_game();
    click = 1'b1; click_x = card_x(10); click_y = card_y(10);
    tick();
    tick();
    click = 1'b0;
    tick();
    check_output("consecutive same card visible", 32'(visible_mask), 32'h0400);
    check_output("consecutive same card moves", 32'(moves), 32'h0);

    pulse_new_game();
    click_card(0);
    click_card(2);
    check_output("mismatch revealed", 32'(visible_mask), 32'h0005);
    tick();
    tick();
    click = 1'b1; click_x = card_x(12); click_y = card_y(12);
    tick();
    click = 1'b0;
    check_output("mismatch last SHOW cycle busy", 32'(busy), 32'h1);
    tick();
    check_output("mismatch exit busy", 32'(busy), 32'h0);
    check_output("mismatch exit visible", 32'(visible_mask), 32'h0);
    check_output("mismatch matched unchanged", 32'(matched_mask), 32'h0);
    check_output("mismatch moves", 32'(moves), 32'h1);
    tick();
    check_output("click on exit edge dropped", 32'(visible_mask), 32'h0);

    pulse_new_game();
    for (int p = 0; p < 8; p++) begin
      click_card(2 * p);
      click_card(2 * p + 1);
      wait_show_end(n);
    end
    check_output("full game matched", 32'(matched_mask), 32'hFFFF);
    check_output("full game done not yet", 32'(game_done), 32'h0);
    tick();
    check_output("full game done", 32'(game_done), 32'h1);
    check_output("full game moves", 32'(moves), 32'h8);
    click_card(3);
    check_output("done click ignored busy", 32'(busy), 32'h0);
    check_output("done click ignored moves", 32'(moves), 32'h8);
    pulse_new_game();
    check_output("new_game visible", 32'(visible_mask), 32'h0);
    check_output("new_game matched", 32'(matched_mask), 32'h0);
    check_output("new_game moves", 32'(moves), 32'h0);
    check_output("new_game game_done", 32'(game_done), 32'h0);

    click_card(0);
    click_card(2);
    tick();
    rst = 1'b1;
    click = 1'b1; click_x = card_x(5); click_y = card_y(5);
    tick();
    rst = 1'b0;
    click = 1'b0;
    check_output("rst mid-SHOW busy", 32'(busy), 32'h0);
    check_output("rst mid-SHOW visible", 32'(visible_mask), 32'h0);
    check_output("rst mid-SHOW moves", 32'(moves), 32'h0);
    tick();
    tick();
    check_output("rst click discarded", 32'(visible_mask), 32'h0);

    click_card(0);
    click_card(1);
    tick();
    new_game = 1'b1;
    click = 1'b1; click_x = card_x(5); click_y = card_y(5);
    tick();
    new_game = 1'b0;
    click = 1'b0;
    check_output("new_game mid-SHOW busy", 32'(busy), 32'h0);
    check_output("new_game mid-SHOW visible", 32'(visible_mask), 32'h0);
    check_output("new_game mid-SHOW matched", 32'(matched_mask), 32'h0);
    tick();
    tick();
    check_output("new_game click discarded", 32'(visible_mask), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/card_flip_ctrl.md
# card_flip_ctrl

Game controller that sequences the card overlay drawers for the Memory Game. It converts mouse click coordinates into a card index on a 4x4 board and runs the reveal/compare/hide state machine. It drives the per-card `visible_mask` consumed by the card drawing stages, plus game progress outputs. It sits in the `pclk` domain between the mouse/click synchroniser and the VGA overlay pipeline.

## Interface
Parameters:
- `GRID_X0`, 50: left edge of column 0, pixels
- `GRID_Y0`, 30: top edge of row 0, pixels
- `CARD_W`, 150: card width, pixels
- `CARD_H`, 120: card height, pixels
- `GAP`, 20: spacing between cards, both axes
- `HOLD_CYCLES`, 40_000_000: show time for a revealed pair (1 s at 40 MHz)

Ports:
- `pclk`  in  1: the only clock
- `rst`  in  1: reset, synchronous, active-high
- `new_game`  in  1: one-cycle pulse, restarts the game
- `click`  in  1: one-cycle pulse, left button press
- `click_x`  in  11: pointer x, valid with `click`
- `click_y`  in  11: pointer y, valid with `click`
- `card_values`  in  64: 4-bit face value per card, card i at [4i+3:4i]; held stable by its source
- `visible_mask`  out  16: bit i drives the draw enable of card i (revealed OR matched)
- `matched_mask`  out  16: bit i set once card i is matched
- `moves`  out  8: number of pairs turned, saturates at 255
- `busy`  out  1: high in SHOW (clicks are ignored)
- `game_done`  out  1: high when `matched_mask` == 16'hFFFF

## Operation
- Card index i = row*4 + col. Card (r,c) occupies x in [GRID_X0 + c*(CARD_W+GAP), +CARD_W) and y in [GRID_Y0 + r*(CARD_H+GAP), +CARD_H), both half-open. Gaps and off-grid positions are misses.
- Stage 1, hit decode: on `click` the decoder registers `hit_valid` and `hit_idx[3:0]`. A miss leaves `hit_valid` = 0. Decoding uses comparisons only, with no division.
- Stage 2, FSM. A hit is accepted only if card `hit_idx` is neither revealed nor matched. Non-accepted hits are dropped.
  - NONE: accepted hit sets reveal bit, stores `first_idx`, goes to ONE.
  - ONE: accepted hit sets reveal bit, stores `second_idx`, loads `hold_cnt` = HOLD_CYCLES-1, increments `moves` (saturating), goes to SHOW.
  - SHOW: `busy` = 1 and all hits are dropped. When `hold_cnt` reaches 0:
    - if the values at `first_idx` and `second_idx` are equal, set both matched bits;
    - in all cases, clear both reveal bits;
    - go to NONE.
- `visible_mask` = reveal | matched, registered.
- `new_game` has priority over every FSM action. Same cycle: reveal, matched, `moves`, `hold_cnt` are cleared and the FSM goes to NONE. `hit_valid` is also cleared, so an in-flight click is discarded.
- When `game_done` = 1 the FSM stays in NONE. Every hit is then non-accepted because all cards are matched.

## Timing
- Reset: FSM goes to NONE. `visible_mask`, `matched_mask`, `moves`, `busy`, `game_done`, `hit_valid`, `hit_idx`, `hold_cnt`, `first_idx`, `second_idx` all go to 0.
- Click latency: `click` sampled at edge k, `hit_valid` high after k, `visible_mask` bit set after edge k+1.
- Acceptance is judged on the FSM state at edge k+1.
  - A click whose stage-2 edge coincides with the SHOW exit edge is dropped, because the state is still SHOW.
  - Two clicks on consecutive cycles are both evaluated in order. If the second click is the same card, it is dropped because that card is already revealed.
- SHOW lasts exactly HOLD_CYCLES cycles. `busy` rises on the same edge the second reveal bit sets. Reveal bits clear and `busy` falls on the same edge that `matched_mask` updates.
- `game_done` is registered and rises on the edge after the final `matched_mask` update.

## Structure
- Shared package `memgame_pkg` holds:
  - `NCARDS` = 16, `GRID_COLS` = 4, `GRID_ROWS` = 4;
  - default geometry constants;
  - FSM state encoding (NONE, ONE, SHOW).
- Sub-module `card_hit_decoder`: implements stage 1. Inputs: `click`, `click_x`, `click_y`, plus geometry parameters. Outputs: registered `hit_valid` and `hit_idx`. It is reused later by the hover highlight.
- The top level holds the FSM, masks, counters and `hold_cnt`.

## Test plan
Run with HOLD_CYCLES = 4.
- Hit boundaries:
  - click (50,30) → card 0 revealed 2 cycles later;
  - click (199,149) → card 0;
  - click (200,30) (gap) → no change;
  - click (220,170) → card 5.
- Match: `card_values` cards 0 and 1 = 4'h3. Click 0, then 1 → `busy` for 4 cycles, `matched_mask` = 16'h0003, `visible_mask` = 16'h0003, `moves` = 1.
- Mismatch: cards 0 and 2 with different values → after 4 SHOW cycles `visible_mask` = 0, `matched_mask` unchanged, `moves` = 1.
- Ignored clicks: click during SHOW, click on a matched card, and the same card clicked twice in ONE → all dropped, `moves` unchanged.
- Full game: match all 8 pairs → `matched_mask` = 16'hFFFF, `game_done` = 1 one cycle later, `moves` = 8. Then `new_game` → all outputs 0 the next cycle.
- Reset and new_game mid-SHOW: assert `rst` (then, separately, `new_game`) in cycle 2 of SHOW → FSM in NONE, masks 0, `busy` 0, and a click in the same cycle is discarded.
